// File: rtl/apb_exe_pkg.sv
// apb_exe_pkg: register map, CTRL/STATUS/IRQ bit positions and sequencer state type
// shared by the APB execution-unit front end.
package apb_exe_pkg;
    localparam int ADDR_ARG_A     = 'h00;
    localparam int ADDR_ARG_B     = 'h04;
    localparam int ADDR_CTRL      = 'h08;
    localparam int ADDR_RESULT    = 'h0C;
    localparam int ADDR_STATUS    = 'h10;
    localparam int ADDR_IRQ       = 'h14;
    localparam int CTRL_START_BIT = 7;
    localparam int STAT_EXE_W     = 4;
    localparam int STAT_DONE_BIT  = 4;
    localparam int STAT_BUSY_BIT  = 5;
    localparam int IRQ_PEND_BIT   = 0;
    localparam int IRQ_EN_BIT     = 1;
    typedef enum logic [1:0] {IDLE, EXEC, CAPT} exe_state_t;
endpackage

// File: rtl/apb_exe_seq.sv
// apb_exe_seq: one-operation sequencer (IDLE -> EXEC -> CAPT -> IDLE) with latency counter.
//  clk_i, rst_i    clock, synchronous active-high reset
//  start_i         launch one operation (honoured only in IDLE)
//  result_i        exe unit result, captured in CAPT
//  status_i        exe unit status {err,ovf,odd,zero}, captured in CAPT
//  busy_o          high in EXEC and CAPT
//  capt_o          one-cycle strobe in CAPT
//  result_o        captured result
//  status_o        captured status
module apb_exe_seq
    import apb_exe_pkg::*;
#(
    parameter int BITS    = 4,
    parameter int EXE_LAT = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [BITS-1:0] result_i,
    input  logic [3:0]      status_i,
    output logic            busy_o,
    output logic            capt_o,
    output logic [BITS-1:0] result_o,
    output logic [3:0]      status_o
);
    localparam int CW = $clog2(EXE_LAT + 1);

    exe_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [BITS-1:0] result_q, result_d;
    logic [3:0]      status_q, status_d;

    assign busy_o   = state_q != IDLE;
    assign capt_o   = state_q == CAPT;
    assign result_o = result_q;
    assign status_o = status_q;

    // EXEC spans EXE_LAT+1 cycles: the count runs down to 0, and CAPT follows the cycle it sits at 0.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = EXEC;
                cnt_d   = CW'(EXE_LAT);
            end
            EXEC: if (cnt_q == '0) state_d = CAPT;
                  else cnt_d = cnt_q - CW'(1);
            default: state_d = IDLE;
        endcase
        result_d = capt_o ? result_i : result_q;
        status_d = capt_o ? status_i : status_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end
endmodule

// File: rtl/apb_exe_ctrl.sv
// apb_exe_ctrl: APB slave front end holding operands/opcode for the exe unit and reading back results.
//  Optional feature macro: APB_EXE_IRQ_EN (adds o_irq and the IRQ register at 0x14).
//  i_clk, i_rst              clock, synchronous active-high reset
//  i_psel .. i_pwdata        APB request
//  o_prdata, o_pready,
//  o_pslverr                 APB response
//  o_argA, o_argB, o_oper    registered operands/opcode to the exe unit
//  i_result, i_status        exe unit outputs
//  o_irq                     pending & enable (APB_EXE_IRQ_EN only)
module apb_exe_ctrl
    import apb_exe_pkg::*;
#(
    parameter int BITS    = 4,
    parameter int N       = 2,
    parameter int APB_AW  = 8,
    parameter int APB_DW  = 32,
    parameter int EXE_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_psel,
    input  logic              i_penable,
    input  logic              i_pwrite,
    input  logic [APB_AW-1:0] i_paddr,
    input  logic [APB_DW-1:0] i_pwdata,
    output logic [APB_DW-1:0] o_prdata,
    output logic              o_pready,
    output logic              o_pslverr,
    output logic [BITS-1:0]   o_argA,
    output logic [BITS-1:0]   o_argB,
    output logic [N-1:0]      o_oper,
    input  logic [BITS-1:0]   i_result,
    input  logic [3:0]        i_status
`ifdef APB_EXE_IRQ_EN
    ,
    output logic              o_irq
`endif
);
    logic [BITS-1:0]   arg_a_q, arg_a_d, arg_b_q, arg_b_d;
    logic [N-1:0]      oper_q, oper_d;
    logic              done_q, done_d;
    logic              busy, capt;
    logic [BITS-1:0]   result;
    logic [3:0]        status;
    logic              sel_a, sel_b, sel_ctrl, sel_res, sel_stat, sel_irq;
    logic              access, xfer, err, wr, start;
    logic [APB_DW-1:0] rd_data, rd_stat, rd_irq;
    logic              unused_pwdata;

    assign sel_a    = i_paddr == APB_AW'(ADDR_ARG_A);
    assign sel_b    = i_paddr == APB_AW'(ADDR_ARG_B);
    assign sel_ctrl = i_paddr == APB_AW'(ADDR_CTRL);
    assign sel_res  = i_paddr == APB_AW'(ADDR_RESULT);
    assign sel_stat = i_paddr == APB_AW'(ADDR_STATUS);

    // Reads of results still in flight stall until the capture cycle has completed.
    assign access    = i_psel & i_penable;
    assign o_pready  = ~(access & ~i_pwrite & (sel_res | sel_stat) & busy);
    assign xfer      = access & o_pready;
    assign err       = ~(sel_a | sel_b | sel_ctrl | sel_res | sel_stat | sel_irq)
                     | (i_pwrite & (sel_res | sel_stat | (busy & (sel_a | sel_b | sel_ctrl))));
    assign o_pslverr = xfer & err;
    assign wr        = xfer & i_pwrite & ~err;
    assign start     = wr & sel_ctrl & i_pwdata[CTRL_START_BIT];
    assign o_prdata  = (xfer & ~i_pwrite & ~err) ? rd_data : '0;

    assign o_argA = arg_a_q;
    assign o_argB = arg_b_q;
    assign o_oper = oper_q;

    assign unused_pwdata = ^i_pwdata;

    always_comb begin
        rd_stat                   = '0;
        rd_stat[STAT_EXE_W-1:0]   = status;
        rd_stat[STAT_DONE_BIT]    = done_q;
        rd_stat[STAT_BUSY_BIT]    = busy;
        rd_data = sel_a    ? APB_DW'(arg_a_q) :
                  sel_b    ? APB_DW'(arg_b_q) :
                  sel_ctrl ? APB_DW'(oper_q)  :
                  sel_res  ? APB_DW'(result)  :
                  sel_stat ? rd_stat          :
                  sel_irq  ? rd_irq           : '0;
    end

    always_comb begin
        arg_a_d = (wr & sel_a) ? i_pwdata[BITS-1:0] : arg_a_q;
        arg_b_d = (wr & sel_b) ? i_pwdata[BITS-1:0] : arg_b_q;
        oper_d  = (wr & sel_ctrl) ? i_pwdata[N-1:0] : oper_q;
        done_d  = start ? 1'b0 : (capt ? 1'b1 : done_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            arg_a_q <= '0;
            arg_b_q <= '0;
            oper_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            arg_a_q <= arg_a_d;
            arg_b_q <= arg_b_d;
            oper_q  <= oper_d;
            done_q  <= done_d;
        end
    end

    apb_exe_seq #(
        .BITS    (BITS),
        .EXE_LAT (EXE_LAT)
    ) u_seq (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .start_i  (start),
        .result_i (i_result),
        .status_i (i_status),
        .busy_o   (busy),
        .capt_o   (capt),
        .result_o (result),
        .status_o (status)
    );

`ifdef APB_EXE_IRQ_EN
    logic pend_q, pend_d, en_q, en_d;

    assign sel_irq = i_paddr == APB_AW'(ADDR_IRQ);
    assign o_irq   = pend_q & en_q;

    // A capture in the same cycle as a write-1-to-clear keeps the pending flag set.
    always_comb begin
        en_d                 = (wr & sel_irq) ? i_pwdata[IRQ_EN_BIT] : en_q;
        pend_d               = capt | (pend_q & ~(wr & sel_irq & i_pwdata[IRQ_PEND_BIT]));
        rd_irq               = '0;
        rd_irq[IRQ_PEND_BIT] = pend_q;
        rd_irq[IRQ_EN_BIT]   = en_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
        end
    end
`else
    assign sel_irq = 1'b0;
    assign rd_irq  = '0;
`endif
endmodule
